// File: rtl/vreg_pkg.sv
// vreg_pkg: shared definitions for the vector register file.
//   - ppp_t and the PPP_* lane-select encodings used on the write path
//   - lane_mask(): DATA_W-bit select mask for a lane mode
// Bit numbering follows the architectural convention: spec bit 0 is the MSB,
// so spec bit j lives at vector index (DATA_W-1-j).
package vreg_pkg;

  typedef logic [2:0] ppp_t;

  localparam ppp_t PPP_FULL = 3'b000;
  localparam ppp_t PPP_HI   = 3'b001;  // architectural bits [0:H-1], MSB half
  localparam ppp_t PPP_LO   = 3'b010;  // architectural bits [H:DATA_W-1], LSB half
  localparam ppp_t PPP_EVEN = 3'b011;  // bytes 0, 2, 4, ... counted from the MSB
  localparam ppp_t PPP_ODD  = 3'b100;  // bytes 1, 3, 5, ... counted from the MSB

  // Widest register the mask helper supports; callers cast down to DATA_W.
  localparam int MAX_DATA_W = 256;

  // Encodings 101..111 fall through to full-word.
  function automatic logic [MAX_DATA_W-1:0] lane_mask(input ppp_t ppp, input int data_w);
    logic [MAX_DATA_W-1:0] m;
    int j;
    m = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        j = data_w - 1 - i;
        case (ppp)
          PPP_HI:   m[i] = (j < data_w / 2);
          PPP_LO:   m[i] = (j >= data_w / 2);
          PPP_EVEN: m[i] = (((j / 8) % 2) == 0);
          PPP_ODD:  m[i] = (((j / 8) % 2) == 1);
          default:  m[i] = 1'b1;
        endcase
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/vreg_file_sb_lane_merge.sv
// lane_merge: combines an old and a new word under a lane-select mode.
//   old_i      : current register value
//   new_data_i : incoming write data
//   ppp_i      : lane-select mode
//   merged_o   : (new & mask) | (old & ~mask)
// Used for both the write path and every read-forwarding path so that the
// stored result and the forwarded result can never disagree.
module lane_merge
  import vreg_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_data_i,
  input  ppp_t              ppp_i,
  output logic [DATA_W-1:0] merged_o
);

  logic [DATA_W-1:0] mask;

  assign mask     = DATA_W'(lane_mask(ppp_i, DATA_W));
  assign merged_o = (new_data_i & mask) | (old_i & ~mask);

endmodule

// File: rtl/vreg_file_sb.sv
// vreg_file_sb: lane-selective register file with same-cycle write forwarding
// and a pending-write scoreboard.
//   clk, rst              : clock, synchronous active-high reset
//   wr_en/ppp/addr/data   : writeback port (clears the destination's pending bit)
//   rsv_en/rsv_addr       : decode reservation (sets a pending bit next edge)
//   flush                 : clear every pending bit, data untouched
//   rd_addr/rd_data       : NUM_RD combinational read ports, port k in slice k
//   rd_busy               : per-port operand still outstanding
//   any_busy              : OR of the registered pending bits
// Register 0 is never written, so it stays at its reset value of zero.
module vreg_file_sb
  import vreg_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_ppp,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       flush,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       any_busy
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  lane_merge #(.DATA_W(DATA_W)) u_wr_merge (
    .old_i      (regs_q[wr_addr]),
    .new_data_i (wr_data),
    .ppp_i      (wr_ppp),
    .merged_o   (wr_merged)
  );

  // Set beats clear (a new producer is in flight); flush beats both.
  always_comb begin
    pending_d = pending_q;
    if (wr_live) pending_d[wr_addr] = 1'b0;
    if (rsv_en && (rsv_addr != '0)) pending_d[rsv_addr] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wr_live) regs_q[wr_addr] <= wr_merged;
      pending_q <= pending_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] fwd;
    logic              hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = regs_q[addr];
    assign hit    = wr_en && (wr_addr == addr);

    lane_merge #(.DATA_W(DATA_W)) u_fwd_merge (
      .old_i      (stored),
      .new_data_i (wr_data),
      .ppp_i      (wr_ppp),
      .merged_o   (fwd)
    );

    // A same-cycle writeback both forwards its data and retires the hazard.
    assign rd_data[k*DATA_W +: DATA_W] = rst ? '0 : ((hit && (addr != '0)) ? fwd : stored);
    assign rd_busy[k] = !rst && pending_q[addr] && !hit;
  end

  assign any_busy = !rst && (|pending_q);

endmodule

// File: tb/tb_vreg_file_sb.sv
module tb_vreg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 64-bit x 32 x 2 ports: directed checks
  logic         d_rst, d_wr_en, d_rsv_en, d_flush;
  logic [2:0]   d_wr_ppp;
  logic [4:0]   d_wr_addr, d_rsv_addr;
  logic [63:0]  d_wr_data;
  logic [9:0]   d_rd_addr;
  logic [127:0] d_rd_data;
  logic [1:0]   d_rd_busy;
  logic         d_any_busy;

  // 32-bit x 16 x 3 ports: randomized checks against the model
  logic         r_rst, r_wr_en, r_rsv_en, r_flush;
  logic [2:0]   r_wr_ppp;
  logic [3:0]   r_wr_addr, r_rsv_addr;
  logic [31:0]  r_wr_data;
  logic [11:0]  r_rd_addr;
  logic [95:0]  r_rd_data;
  logic [2:0]   r_rd_busy;
  logic         r_any_busy;

  vreg_file_sb #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2)) u_dut64 (
    .clk(clk), .rst(d_rst), .wr_en(d_wr_en), .wr_ppp(d_wr_ppp), .wr_addr(d_wr_addr),
    .wr_data(d_wr_data), .rsv_en(d_rsv_en), .rsv_addr(d_rsv_addr), .flush(d_flush),
    .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_busy(d_rd_busy), .any_busy(d_any_busy)
  );

  vreg_file_sb #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) u_dut32 (
    .clk(clk), .rst(r_rst), .wr_en(r_wr_en), .wr_ppp(r_wr_ppp), .wr_addr(r_wr_addr),
    .wr_data(r_wr_data), .rsv_en(r_rsv_en), .rsv_addr(r_rsv_addr), .flush(r_flush),
    .rd_addr(r_rd_addr), .rd_data(r_rd_data), .rd_busy(r_rd_busy), .any_busy(r_any_busy)
  );

  // Reference merge, byte by byte in architectural order (byte 0 = MSB byte).
  function automatic logic [63:0] model_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                              input logic [2:0] ppp, input int w);
    int nb;
    logic [63:0] r;
    nb = w / 8;
    r = old_v;
    for (int b = 0; b < nb; b++) begin
      bit sel;
      case (ppp)
        3'd1:    sel = (b < nb / 2);
        3'd2:    sel = (b >= nb / 2);
        3'd3:    sel = ((b % 2) == 0);
        3'd4:    sel = ((b % 2) == 1);
        default: sel = 1'b1;
      endcase
      if (sel) r[(nb-1-b)*8 +: 8] = new_v[(nb-1-b)*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic d_idle();
    d_wr_en = 0; d_rsv_en = 0; d_flush = 0; d_wr_ppp = 0;
    d_wr_addr = 0; d_rsv_addr = 0; d_wr_data = 0;
  endtask

  logic [31:0] m_reg [16];
  logic        m_pend [16];

  initial begin
    logic [63:0] ones;
    logic [63:0] exp_t [4];
    logic [2:0]  ppp_t [4];
    ones = '1;
    ppp_t = '{3'd2, 3'd1, 3'd3, 3'd4};
    exp_t = '{64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF,
              64'h00FF00FF00FF00FF, 64'hFF00FF00FF00FF00};

    // Pin the reference merge with hand-computed values.
    chk("model_lo",   model_merge(ones, 64'h0, 3'd2, 64), 64'hFFFFFFFF00000000);
    chk("model_even", model_merge(ones, 64'h0, 3'd3, 64), 64'h00FF00FF00FF00FF);
    chk("model_odd32", model_merge(64'h0, 64'hFFFFFFFF, 3'd4, 32), 64'h00FF00FF);
    chk("model_dflt", model_merge(64'h0, 64'h1234, 3'd7, 32), 64'h1234);

    r_rst = 1; r_wr_en = 0; r_rsv_en = 0; r_flush = 0; r_wr_ppp = 0;
    r_wr_addr = 0; r_rsv_addr = 0; r_wr_data = 0; r_rd_addr = 0;

    // ---- directed, 64-bit instance ----
    d_idle(); d_rst = 1; d_rd_addr = {5'd5, 5'd5};
    step(); step();
    settle();
    chk("rst_rd0", d_rd_data[63:0], 0);
    chk("rst_any", {63'b0, d_any_busy}, 0);
    step(); d_rst = 0;

    d_wr_en = 1; d_wr_addr = 5; d_wr_data = 64'h0123456789ABCDEF;
    settle();
    chk("fwd_full_p0", d_rd_data[63:0], 64'h0123456789ABCDEF);
    step(); d_idle(); settle();
    chk("r5_p0", d_rd_data[63:0], 64'h0123456789ABCDEF);
    chk("r5_p1", d_rd_data[127:64], 64'h0123456789ABCDEF);

    d_wr_en = 1; d_wr_addr = 0; d_wr_data = ones; d_rd_addr = {5'd0, 5'd0};
    settle();
    chk("r0_fwd_p0", d_rd_data[63:0], 0);
    chk("r0_fwd_p1", d_rd_data[127:64], 0);
    step(); d_idle(); settle();
    chk("r0_after", d_rd_data[63:0], 0);

    for (int t = 0; t < 4; t++) begin
      d_wr_en = 1; d_wr_addr = 7; d_wr_ppp = 0; d_wr_data = ones;
      step();
      d_wr_ppp = ppp_t[t]; d_wr_data = 0; d_rd_addr = {5'd7, 5'd7};
      settle();
      chk($sformatf("lane_fwd_p1_%0d", t), d_rd_data[127:64], exp_t[t]);
      chk($sformatf("lane_fwd_p0_%0d", t), d_rd_data[63:0], exp_t[t]);
      step(); d_idle(); settle();
      chk($sformatf("lane_st_p1_%0d", t), d_rd_data[127:64], exp_t[t]);
      chk($sformatf("lane_st_p0_%0d", t), d_rd_data[63:0], exp_t[t]);
    end

    d_rsv_en = 1; d_rsv_addr = 3;
    step(); d_idle(); d_rd_addr = {5'd0, 5'd3}; settle();
    chk("rsv_busy", {62'b0, d_rd_busy}, 64'd1);
    chk("rsv_any", {63'b0, d_any_busy}, 1);
    d_wr_en = 1; d_wr_addr = 3; d_wr_data = 64'hCAFEF00DDEADBEEF;
    settle();
    chk("wb_busy", {62'b0, d_rd_busy}, 0);
    chk("wb_fwd", d_rd_data[63:0], 64'hCAFEF00DDEADBEEF);
    step(); d_idle(); settle();
    chk("wb_cleared", {62'b0, d_rd_busy}, 0);
    chk("wb_any", {63'b0, d_any_busy}, 0);

    d_rsv_en = 1; d_rsv_addr = 9; d_wr_en = 1; d_wr_addr = 9; d_wr_data = 64'h1111;
    step(); d_idle(); d_rd_addr = {5'd0, 5'd9}; settle();
    chk("set_wins", {62'b0, d_rd_busy}, 1);
    chk("set_wins_data", d_rd_data[63:0], 64'h1111);
    d_rsv_en = 1; d_rsv_addr = 9; d_wr_en = 1; d_wr_addr = 9; d_wr_data = 64'h2222; d_flush = 1;
    step(); d_idle(); settle();
    chk("flush_busy", {62'b0, d_rd_busy}, 0);
    chk("flush_any", {63'b0, d_any_busy}, 0);
    chk("flush_data", d_rd_data[63:0], 64'h2222);
    d_rsv_en = 1; d_rsv_addr = 9; settle();
    chk("rsv_not_same_cycle", {62'b0, d_rd_busy}, 0);
    step(); d_idle(); settle();
    chk("rsv_next_cycle", {62'b0, d_rd_busy}, 1);
    d_flush = 1; step(); d_idle();

    d_rsv_en = 1; d_rsv_addr = 2; step();
    d_rsv_addr = 4; step();
    d_rsv_addr = 6; step(); d_idle();
    d_rd_addr = {5'd4, 5'd5}; settle();
    chk("pre_rst_any", {63'b0, d_any_busy}, 1);
    chk("pre_rst_busy1", {62'b0, d_rd_busy}, 2);
    d_rst = 1; d_wr_en = 1; d_wr_addr = 5; d_wr_data = ones; settle();
    chk("in_rst_rd0", d_rd_data[63:0], 0);
    chk("in_rst_rd1", d_rd_data[127:64], 0);
    chk("in_rst_busy", {62'b0, d_rd_busy}, 0);
    chk("in_rst_any", {63'b0, d_any_busy}, 0);
    step(); d_rst = 0; d_idle(); d_rd_addr = {5'd7, 5'd5}; settle();
    chk("post_rst_any", {63'b0, d_any_busy}, 0);
    chk("post_rst_r5", d_rd_data[63:0], 0);
    chk("post_rst_r7", d_rd_data[127:64], 0);
    d_rsv_en = 1; d_rsv_addr = 0; d_rd_addr = 0;
    step(); d_idle(); settle();
    chk("rsv_r0_busy", {62'b0, d_rd_busy}, 0);
    chk("rsv_r0_any", {63'b0, d_any_busy}, 0);
    d_wr_en = 1; d_wr_addr = 4; d_wr_data = 64'h4444; step(); d_idle();
    d_rd_addr = {5'd0, 5'd4}; settle();
    chk("post_rst_write", d_rd_data[63:0], 64'h4444);

    // ---- randomized, 32-bit instance, checked every cycle ----
    for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      r_rst      = (cyc < 2) || ($urandom_range(0, 99) == 0);
      r_wr_en    = 1'($urandom_range(0, 1));
      r_wr_ppp   = 3'($urandom_range(0, 7));
      r_wr_addr  = 4'($urandom_range(0, 15));
      r_wr_data  = $urandom;
      r_rsv_en   = ($urandom_range(0, 2) == 0);
      r_rsv_addr = 4'($urandom_range(0, 15));
      r_flush    = ($urandom_range(0, 39) == 0);
      r_rd_addr  = 12'($urandom_range(0, 4095));
      settle();
      begin
        logic [3:0]  a;
        logic [63:0] e;
        logic        eb;
        logic        ea;
        ea = 0;
        for (int i = 0; i < 16; i++) ea = ea | m_pend[i];
        chk($sformatf("rnd_any c%0d", cyc), {63'b0, r_any_busy}, {63'b0, ea && !r_rst});
        for (int k = 0; k < 3; k++) begin
          a = r_rd_addr[k*4 +: 4];
          if (r_rst) e = 0;
          else if (r_wr_en && r_wr_addr == a && a != 0)
            e = model_merge({32'b0, m_reg[a]}, {32'b0, r_wr_data}, r_wr_ppp, 32);
          else e = {32'b0, m_reg[a]};
          eb = !r_rst && m_pend[a] && !(r_wr_en && r_wr_addr == a);
          chk($sformatf("rnd_data c%0d p%0d", cyc, k), {32'b0, r_rd_data[k*32 +: 32]}, e);
          chk($sformatf("rnd_busy c%0d p%0d", cyc, k), {63'b0, r_rd_busy[k]}, {63'b0, eb});
        end
      end
      step();
      if (r_rst) begin
        for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
      end else begin
        if (r_wr_en && r_wr_addr != 0) begin
          logic [63:0] mm;
          mm = model_merge({32'b0, m_reg[r_wr_addr]}, {32'b0, r_wr_data}, r_wr_ppp, 32);
          m_reg[r_wr_addr] = mm[31:0];
          m_pend[r_wr_addr] = 0;
        end
        if (r_rsv_en && r_rsv_addr != 0) m_pend[r_rsv_addr] = 1;
        if (r_flush) for (int i = 0; i < 16; i++) m_pend[i] = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
